// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite five-channel bundle between a master adaptor and a register-file responder.
interface axi4_lite_slave_regfile_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid,    input wready,
      input  bresp, bvalid,           output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid,    output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid,    output wready,
      output bresp, bvalid,           input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid,    input rready
   );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite responder backed by NUM_REGS 32-bit byte-writable registers.
// Independent write (W_IDLE/W_RESP) and read (R_IDLE/R_DATA) FSMs; out-of-range
// accesses return SLVERR without touching the registers.
module axi4_lite_slave_regfile #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   axi4_lite_slave_regfile_if.slave   bus,
   output logic [NUM_REGS*32-1:0]     reg_q
);

   localparam int                    IDX_W     = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-3:0] REG_LIMIT = (ADDR_WIDTH-2)'(NUM_REGS);
   localparam logic [1:0]            RESP_OKAY   = 2'b00;
   localparam logic [1:0]            RESP_SLVERR = 2'b10;

   typedef enum logic { W_IDLE, W_RESP } w_state_t;
   typedef enum logic { R_IDLE, R_DATA } r_state_t;

   w_state_t w_state;
   r_state_t r_state;

   logic [31:0]           regs [NUM_REGS];
   logic                  aw_held;
   logic                  w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  commit;
   logic [ADDR_WIDTH-1:0] commit_addr;
   logic [31:0]           commit_data;
   logic [3:0]            commit_strb;
   logic                  unused_bits;

   // Word index lies in bits [ADDR_WIDTH-1:2]; anything at or beyond NUM_REGS is an error.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      return addr[ADDR_WIDTH-1:2] < REG_LIMIT;
   endfunction

   assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0]};

   // Merge live handshakes with already-latched halves so the commit can happen on the
   // same edge that delivers the second (or both) of AW and W.
   always_comb begin
      aw_hs       = bus.awvalid && bus.awready;
      w_hs        = bus.wvalid && bus.wready;
      commit      = (aw_held || aw_hs) && (w_held || w_hs);
      commit_addr = aw_hs ? bus.awaddr : aw_addr_q;
      commit_data = w_hs  ? bus.wdata  : w_data_q;
      commit_strb = w_hs  ? bus.wstrb  : w_strb_q;
   end

   // Write FSM: collects AW and W in any order, commits strobed bytes, holds B until accepted.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state     <= W_IDLE;
         aw_held     <= 1'b0;
         w_held      <= 1'b0;
         aw_addr_q   <= '0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         bus.awready <= 1'b1;
         bus.wready  <= 1'b1;
         bus.bvalid  <= 1'b0;
         bus.bresp   <= RESP_OKAY;
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs[k] <= '0;
         end
      end else begin
         case (w_state)
            W_IDLE: begin
               if (commit) begin
                  if (in_range(commit_addr)) begin
                     for (int unsigned b = 0; b < 4; b++) begin
                        if (commit_strb[b]) begin
                           regs[commit_addr[2 +: IDX_W]][8*b +: 8] <= commit_data[8*b +: 8];
                        end
                     end
                     bus.bresp <= RESP_OKAY;
                  end else begin
                     bus.bresp <= RESP_SLVERR;
                  end
                  bus.bvalid  <= 1'b1;
                  aw_held     <= 1'b0;
                  w_held      <= 1'b0;
                  bus.awready <= 1'b0;
                  bus.wready  <= 1'b0;
                  w_state     <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_held     <= 1'b1;
                     aw_addr_q   <= bus.awaddr;
                     bus.awready <= 1'b0;
                  end
                  if (w_hs) begin
                     w_held     <= 1'b1;
                     w_data_q   <= bus.wdata;
                     w_strb_q   <= bus.wstrb;
                     bus.wready <= 1'b0;
                  end
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bus.bvalid  <= 1'b0;
                  bus.awready <= 1'b1;
                  bus.wready  <= 1'b1;
                  w_state     <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read FSM: samples the register on the AR edge (pre-write value), holds R until accepted.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= R_IDLE;
         bus.arready <= 1'b1;
         bus.rvalid  <= 1'b0;
         bus.rresp   <= RESP_OKAY;
         bus.rdata   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (bus.arvalid && bus.arready) begin
                  if (in_range(bus.araddr)) begin
                     bus.rdata <= regs[bus.araddr[2 +: IDX_W]];
                     bus.rresp <= RESP_OKAY;
                  end else begin
                     bus.rdata <= '0;
                     bus.rresp <= RESP_SLVERR;
                  end
                  bus.rvalid  <= 1'b1;
                  bus.arready <= 1'b0;
                  r_state     <= R_DATA;
               end
            end
            R_DATA: begin
               if (bus.rready) begin
                  bus.rvalid  <= 1'b0;
                  bus.arready <= 1'b1;
                  r_state     <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Flatten the register bank onto reg_q with no added latency.
   always_comb begin
      reg_q = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         reg_q[32*k +: 32] = regs[k];
      end
   end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Scoreboard bench for axi4_lite_slave_regfile: expected B/R responses are queued when a
// request is driven and checked by monitors when the response handshake occurs.
module tb_axi4_lite_slave_regfile;

   localparam int AW = 32;
   localparam int NR = 8;

   logic            aclk = 1'b0;
   logic            aresetn = 1'b0;
   logic [NR*32-1:0] reg_q;

   axi4_lite_slave_regfile_if #(.ADDR_WIDTH(AW)) bus ();

   axi4_lite_slave_regfile #(.ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus.slave),
      .reg_q   (reg_q)
   );

   always #5 aclk = ~aclk;

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;

   logic [31:0] model [NR];
   logic [1:0]  b_q [$];
   logic [33:0] r_q [$];

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [NR*32-1:0] model_vec();
      logic [NR*32-1:0] v;
      v = '0;
      for (int k = 0; k < NR; k++) v[32*k +: 32] = model[k];
      return v;
   endfunction

   task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] mask;
      if (a < 32'h20) begin
         mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
         model[a[4:2]] = (model[a[4:2]] & ~mask) | (d & mask);
         b_q.push_back(2'b00);
      end else begin
         b_q.push_back(2'b10);
      end
   endtask

   task automatic push_read(input logic [31:0] a);
      if (a < 32'h20) r_q.push_back({2'b00, model[a[4:2]]});
      else            r_q.push_back({2'b10, 32'h0});
   endtask

   task automatic drive_aw(input logic [31:0] a);
      int n = 0;
      bus.awaddr = a; bus.awvalid = 1'b1;
      while (!bus.awready && n < 20) begin tick(); n++; end
      n_cmp++;
      if (n >= 20) begin n_fail++; $display("FAIL aw_accept: awready stayed %b, required 1", bus.awready); end
      tick();
      bus.awvalid = 1'b0;
   endtask

   task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
      while (!bus.wready && n < 20) begin tick(); n++; end
      n_cmp++;
      if (n >= 20) begin n_fail++; $display("FAIL w_accept: wready stayed %b, required 1", bus.wready); end
      tick();
      bus.wvalid = 1'b0;
   endtask

   task automatic drive_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      bus.awaddr = a; bus.awvalid = 1'b1;
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
      while (!(bus.awready && bus.wready) && n < 20) begin tick(); n++; end
      n_cmp++;
      if (n >= 20) begin n_fail++; $display("FAIL aw_w_accept: awready=%b wready=%b, required 1 1", bus.awready, bus.wready); end
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
   endtask

   task automatic drive_ar(input logic [31:0] a);
      int n = 0;
      bus.araddr = a; bus.arvalid = 1'b1;
      while (!bus.arready && n < 20) begin tick(); n++; end
      n_cmp++;
      if (n >= 20) begin n_fail++; $display("FAIL ar_accept: arready stayed %b, required 1", bus.arready); end
      tick();
      bus.arvalid = 1'b0;
   endtask

   task automatic wait_b();
      int n = 0;
      while (!bus.bvalid && n < 20) begin tick(); n++; end
      n_cmp++;
      if (n >= 20) begin n_fail++; $display("FAIL b_timeout: bvalid=%b, required 1", bus.bvalid); end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic wait_r();
      int n = 0;
      while (!bus.rvalid && n < 20) begin tick(); n++; end
      n_cmp++;
      if (n >= 20) begin n_fail++; $display("FAIL r_timeout: rvalid=%b, required 1", bus.rvalid); end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
   endtask

   // Scoreboard pop side: a response handshake happens on the next rising edge.
   always @(negedge aclk) begin
      if (aresetn && bus.bvalid && bus.bready) begin
         n_cmp++;
         if (b_q.size() == 0) begin
            n_fail++; $display("FAIL b_unexpected: bresp=%b, required no response", bus.bresp);
         end else begin
            logic [1:0] exp_b;
            exp_b = b_q.pop_front();
            if (bus.bresp !== exp_b) begin
               n_fail++; $display("FAIL bresp: got %b, required %b", bus.bresp, exp_b);
            end
         end
      end
   end

   always @(negedge aclk) begin
      if (aresetn && bus.rvalid && bus.rready) begin
         n_cmp++;
         if (r_q.size() == 0) begin
            n_fail++; $display("FAIL r_unexpected: rresp=%b rdata=%h, required no response", bus.rresp, bus.rdata);
         end else begin
            logic [33:0] exp_r;
            exp_r = r_q.pop_front();
            if ({bus.rresp, bus.rdata} !== exp_r) begin
               n_fail++; $display("FAIL rresp_rdata: got %b/%h, required %b/%h", bus.rresp, bus.rdata, exp_r[33:32], exp_r[31:0]);
            end
         end
      end
   end

   task automatic test_reset();
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      for (int k = 0; k < NR; k++) model[k] = '0;
      aresetn = 1'b0;
      tick(); tick();
      aresetn = 1'b1;
      tick();
      n_cmp++; if (reg_q !== '0) begin n_fail++; $display("FAIL reset_reg_q: got %h, required 0", reg_q); end
      n_cmp++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got b=%b r=%b, required 0 0", bus.bvalid, bus.rvalid); end
      n_cmp++; if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin n_fail++; $display("FAIL reset_resp: got %b %b %h, required 0", bus.bresp, bus.rresp, bus.rdata); end
      n_cmp++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b%b%b, required 111", bus.awready, bus.wready, bus.arready); end
   endtask

   task automatic test_same_cycle_write();
      push_write(32'h8, 32'hDEADBEEF, 4'hF);
      drive_aw_w(32'h8, 32'hDEADBEEF, 4'hF);
      n_cmp++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL write_latency_bvalid: got %b, required 1", bus.bvalid); end
      n_cmp++; if (reg_q[95:64] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_latency_reg2: got %h, required deadbeef", reg_q[95:64]); end
      wait_b();
      push_read(32'h8);
      drive_ar(32'h8);
      n_cmp++; if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL read_latency_rvalid: got %b, required 1", bus.rvalid); end
      wait_r();
   endtask

   task automatic test_aw_before_w();
      push_write(32'h4, 32'h12345678, 4'hF);
      drive_aw(32'h4);
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL aw_held_awready: cycle %0d got %b, required 0", i, bus.awready); end
         n_cmp++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL aw_held_bvalid: cycle %0d got %b, required 0", i, bus.bvalid); end
         n_cmp++; if (reg_q[63:32] !== 32'h0) begin n_fail++; $display("FAIL aw_held_reg1: cycle %0d got %h, required 0", i, reg_q[63:32]); end
         if (i < 2) tick();
      end
      drive_w(32'h12345678, 4'hF);
      n_cmp++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL late_w_bvalid: got %b, required 1", bus.bvalid); end
      n_cmp++; if (reg_q[63:32] !== 32'h12345678) begin n_fail++; $display("FAIL late_w_reg1: got %h, required 12345678", reg_q[63:32]); end
      wait_b();
   endtask

   task automatic test_byte_strobe();
      push_write(32'h4, 32'hFFFFFFFF, 4'hF);
      drive_aw_w(32'h4, 32'hFFFFFFFF, 4'hF);
      wait_b();
      push_write(32'h4, 32'h000000AA, 4'h1);
      drive_aw_w(32'h4, 32'h000000AA, 4'h1);
      wait_b();
      push_read(32'h4);
      drive_ar(32'h4);
      wait_r();
      // strobe 0 leaves the register unchanged but still answers OKAY
      push_write(32'h6, 32'h55555555, 4'h0);
      drive_aw_w(32'h6, 32'h55555555, 4'h0);
      wait_b();
      push_read(32'h7);
      drive_ar(32'h7);
      wait_r();
      n_cmp++; if (reg_q !== model_vec()) begin n_fail++; $display("FAIL strobe_reg_q: got %h, required %h", reg_q, model_vec()); end
   endtask

   task automatic test_out_of_range();
      push_write(32'h20, 32'hA5A5A5A5, 4'hF);
      drive_aw_w(32'h20, 32'hA5A5A5A5, 4'hF);
      wait_b();
      push_write(32'h8000_0008, 32'h0BADF00D, 4'hF);
      drive_aw_w(32'h8000_0008, 32'h0BADF00D, 4'hF);
      wait_b();
      n_cmp++; if (reg_q !== model_vec()) begin n_fail++; $display("FAIL oor_reg_q: got %h, required %h", reg_q, model_vec()); end
      push_read(32'h20);
      drive_ar(32'h20);
      wait_r();
      push_write(32'h1C, 32'h7777_0001, 4'hF);
      drive_aw_w(32'h1C, 32'h7777_0001, 4'hF);
      wait_b();
      push_read(32'h1F);
      drive_ar(32'h1F);
      wait_r();
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_rd;
      push_write(32'h10, 32'hC0FFEE00, 4'hF);
      push_read(32'h8);
      exp_rd = model[2];
      drive_aw_w(32'h10, 32'hC0FFEE00, 4'hF);
      drive_ar(32'h8);
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if ({bus.bvalid, bus.rvalid} !== 2'b11) begin n_fail++; $display("FAIL hold_valid: cycle %0d got b=%b r=%b, required 1 1", i, bus.bvalid, bus.rvalid); end
         n_cmp++; if ({bus.bresp, bus.rresp, bus.rdata} !== {4'b0000, exp_rd}) begin n_fail++; $display("FAIL hold_payload: cycle %0d got %b %b %h, required 00 00 %h", i, bus.bresp, bus.rresp, bus.rdata, exp_rd); end
         n_cmp++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin n_fail++; $display("FAIL hold_ready: cycle %0d got %b%b%b, required 000", i, bus.awready, bus.wready, bus.arready); end
         tick();
      end
      wait_b();
      wait_r();
      n_cmp++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_fail++; $display("FAIL ready_restore: got %b%b%b, required 111", bus.awready, bus.wready, bus.arready); end
   endtask

   task automatic test_read_during_commit();
      push_read(32'hC);
      push_write(32'hC, 32'h3C3C3C3C, 4'hF);
      bus.awaddr = 32'hC; bus.awvalid = 1'b1;
      bus.wdata = 32'h3C3C3C3C; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      bus.araddr = 32'hC; bus.arvalid = 1'b1;
      n_cmp++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_fail++; $display("FAIL collide_ready: got %b%b%b, required 111", bus.awready, bus.wready, bus.arready); end
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      wait_b();
      wait_r();
      n_cmp++; if (reg_q !== model_vec()) begin n_fail++; $display("FAIL collide_reg_q: got %h, required %h", reg_q, model_vec()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, d;
      logic [3:0]  s;
      for (int i = 0; i < 8; i++) begin
         a = 32'($urandom_range(0, 9)) << 2;
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         push_write(a, d, s);
         drive_aw_w(a, d, s);
         wait_b();
      end
      for (int i = 0; i < 10; i++) begin
         a = 32'(i) << 2;
         push_read(a);
         drive_ar(a);
         wait_r();
      end
      n_cmp++; if (reg_q !== model_vec()) begin n_fail++; $display("FAIL b2b_reg_q: got %h, required %h", reg_q, model_vec()); end
   endtask

   task automatic test_reset_mid_txn();
      push_write(32'h14, 32'hCAFEF00D, 4'hF);
      push_read(32'h14);
      drive_aw_w(32'h14, 32'hCAFEF00D, 4'hF);
      drive_ar(32'h14);
      n_cmp++; if ({bus.bvalid, bus.rvalid} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_valid: got b=%b r=%b, required 1 1", bus.bvalid, bus.rvalid); end
      aresetn = 1'b0;
      #1;
      n_cmp++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin n_fail++; $display("FAIL async_reset_valid: got b=%b r=%b, required 0 0", bus.bvalid, bus.rvalid); end
      n_cmp++; if (reg_q !== '0) begin n_fail++; $display("FAIL async_reset_reg_q: got %h, required 0", reg_q); end
      b_q.delete();
      r_q.delete();
      for (int k = 0; k < NR; k++) model[k] = '0;
      tick(); tick();
      aresetn = 1'b1;
      tick();
      n_cmp++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_fail++; $display("FAIL post_reset_ready: got %b%b%b, required 111", bus.awready, bus.wready, bus.arready); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin n_fail++; $display("FAIL stale_response: cycle %0d got b=%b r=%b, required 0 0", i, bus.bvalid, bus.rvalid); end
         tick();
      end
      push_read(32'h14);
      drive_ar(32'h14);
      wait_r();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_same_cycle_write();
      test_aw_before_w();
      test_byte_strobe();
      test_out_of_range();
      test_backpressure();
      test_read_during_commit();
      test_back_to_back();
      test_reset_mid_txn();
      tick();
      n_cmp++;
      if (b_q.size() != 0 || r_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d B and %0d R pending, required 0 0", b_q.size(), r_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
